reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- DATA_W, 32, register width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of independent read ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = no forwarding.
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write destination.
- wr_data  in  DATA_W  write data.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data; port i at bits [i*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  port i's register has a pending (issued, not yet written) producer.
- issue_en  in  1  marks issue_addr as pending.
- issue_addr  in  ADDR_W  destination being claimed.
- any_busy  out  1  OR of all pending bits.

Function
REQ-003 Register 0 SHALL read as 0 at all times; writes and issues to address 0 SHALL be ignored.
REQ-004 A write with wr_en=1 and wr_addr!=0 SHALL update the register at the rising edge; the new value is visible on reads the following cycle (write latency 1).
REQ-005 Reads SHALL be combinational from rd_addr, 0 cycles latency, all ports independent; multiple ports reading the same address SHALL return identical data.
REQ-006 With BYPASS=1, when wr_en=1, wr_addr!=0 and wr_addr==rd_addr[i], rd_data[i] SHALL equal wr_data in the same cycle; with BYPASS=0 it SHALL return the stored (old) value.
REQ-007 A pending bit per register SHALL be kept; issue_en=1 with issue_addr!=0 SHALL set pending[issue_addr] at the edge.
REQ-008 wr_en=1 with wr_addr!=0 SHALL clear pending[wr_addr] at the edge.
REQ-009 Simultaneous issue and write to the same nonzero address SHALL leave the pending bit set (new producer wins); the data write still occurs.
REQ-010 Issue to an already-pending register SHALL keep it pending (no counting); write to a non-pending register SHALL write data and leave pending clear.
REQ-011 rd_busy[i] SHALL equal pending[rd_addr[i]], except that with BYPASS=1 it SHALL be 0 when a same-cycle write to that nonzero address is present; rd_busy for address 0 SHALL be 0.
REQ-012 any_busy SHALL be the OR of all pending bits, registered-state based (no combinational path from inputs).
REQ-013 Out-of-range parameters (NUM_RD<1, ADDR_W<1) SHALL be rejected at elaboration.

Reset
REQ-014 While rst=1 at a rising edge, all registers SHALL clear to 0 and all pending bits to 0; wr_en and issue_en in that cycle SHALL be ignored.
REQ-015 After reset: rd_data all 0, rd_busy all 0, any_busy 0; reset mid-operation discards all pending state and data.

Structure
REQ-016 Default parameter values and the port-slicing width constants SHALL live in shared package reg_file_pkg.
REQ-017 The write-address decode SHALL be one sub-module, reg_file_dec (ADDR_W-to-DEPTH one-hot with enable), reused for write and issue decode.
REQ-018 Storage and pending bits SHALL be flip-flops updated only in the clocked process; no latches.

Verification
REQ-019 Reset then read all addresses on every port -> all rd_data 0, rd_busy 0, any_busy 0.
REQ-020 Write 0xDEADBEEF to R5, next cycle read R5 on ports 0 and 1 -> both 0xDEADBEEF; write 0x1234 to R0 -> R0 reads 0.
REQ-021 BYPASS=1: write 0xA5A5A5A5 to R7 while reading R7 same cycle -> rd_data 0xA5A5A5A5 that cycle; BYPASS=0 -> old value 0.
REQ-022 Issue R3 -> next cycle rd_busy=1, any_busy=1; write R3=0x42 -> rd_busy 0 from next cycle (0 same cycle with BYPASS=1), data 0x42.
REQ-023 Same-cycle issue and write to R9 with 0x77 -> R9=0x77, still pending; issue R0 -> never busy.
REQ-024 Write R2=0x55, issue R4, assert rst one cycle -> R2 reads 0, any_busy 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared defaults and port-slicing width helpers for the multi-port register file.
// No ports; imported by the interface, decoder and top.
package reg_file_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 4;
   localparam int unsigned NUM_RD_DEF = 2;
   localparam int unsigned BYPASS_DEF = 1;

   // Packed read-bus widths for the default configuration
   localparam int unsigned RD_ADDR_W_DEF = NUM_RD_DEF * ADDR_W_DEF;
   localparam int unsigned RD_DATA_W_DEF = NUM_RD_DEF * DATA_W_DEF;

   // Width of a bus packing n fields of w bits each
   function automatic int unsigned packed_w(input int unsigned n, input int unsigned w);
      return n * w;
   endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Write, issue and read bus of the multi-port register file.
// master: wr_en/wr_addr/wr_data, rd_addr, issue_en/issue_addr out; rd_data, rd_busy, any_busy in.
// slave : the mirror image, used by reg_file_mp.
interface reg_file_mp_if
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned NUM_RD = NUM_RD_DEF
);

   logic                                   wr_en;
   logic [ADDR_W-1:0]                      wr_addr;
   logic [DATA_W-1:0]                      wr_data;
   logic [packed_w(NUM_RD, ADDR_W)-1:0]    rd_addr;
   logic [packed_w(NUM_RD, DATA_W)-1:0]    rd_data;
   logic [NUM_RD-1:0]                      rd_busy;
   logic                                   issue_en;
   logic [ADDR_W-1:0]                      issue_addr;
   logic                                   any_busy;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr, issue_en, issue_addr,
      input  rd_data, rd_busy, any_busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr, issue_en, issue_addr,
      output rd_data, rd_busy, any_busy
   );

endinterface

// File: rtl/reg_file_dec.sv
// ADDR_W-to-DEPTH one-hot decoder with enable; shared by write and issue paths.
// en    : decode enable, all outputs 0 when low
// addr  : address to decode
// sel_c : combinational one-hot select
module reg_file_dec
   import reg_file_pkg::*;
#(
   parameter  int unsigned ADDR_W = ADDR_W_DEF,
   localparam int unsigned DEPTH  = 2 ** ADDR_W
) (
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   output logic [DEPTH-1:0]  sel_c
);

   if (ADDR_W < 1) begin : g_bad_addr_w
      $fatal(1, "reg_file_dec: ADDR_W must be at least 1");
   end

   always_comb begin
      sel_c = '0;
      if (en) begin
         sel_c[addr] = 1'b1;
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with per-register pending (scoreboard) bits.
// clk : rising-edge clock
// rst : synchronous active-high reset, clears data and pending bits
// bus : reg_file_mp_if slave; one write port, one issue port,
//       NUM_RD combinational read ports with busy flags, any_busy summary
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned NUM_RD = NUM_RD_DEF,
   parameter int unsigned BYPASS = BYPASS_DEF
) (
   input logic           clk,
   input logic           rst,
   reg_file_mp_if.slave  bus
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   if (NUM_RD < 1) begin : g_bad_num_rd
      $fatal(1, "reg_file_mp: NUM_RD must be at least 1");
   end
   if (ADDR_W < 1) begin : g_bad_addr_w
      $fatal(1, "reg_file_mp: ADDR_W must be at least 1");
   end

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  pending;
   logic [DEPTH-1:0]  pending_nxt;
   logic              any_busy_q;
   logic              wr_hit;
   logic              iss_hit;
   logic [DEPTH-1:0]  wr_sel;
   logic [DEPTH-1:0]  iss_sel;

   // Address 0 is hardwired; qualifying the enables keeps bit 0 of both selects clear
   assign wr_hit  = bus.wr_en    && (bus.wr_addr    != '0);
   assign iss_hit = bus.issue_en && (bus.issue_addr != '0);

   reg_file_dec #(.ADDR_W(ADDR_W)) u_wr_dec (
      .en    (wr_hit),
      .addr  (bus.wr_addr),
      .sel_c (wr_sel)
   );

   reg_file_dec #(.ADDR_W(ADDR_W)) u_iss_dec (
      .en    (iss_hit),
      .addr  (bus.issue_addr),
      .sel_c (iss_sel)
   );

   // Write clears its register's pending bit; a same-cycle issue re-sets it (new producer wins)
   always_comb begin
      pending_nxt = (pending & ~wr_sel) | iss_sel;
   end

   // Storage, pending bits and the registered busy summary
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         pending    <= '0;
         any_busy_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
               regs[i] <= bus.wr_data;
            end
         end
         pending    <= pending_nxt;
         any_busy_q <= |pending_nxt;
      end
   end

   assign bus.any_busy = any_busy_q;

   // Combinational read ports with optional same-cycle write forwarding
   for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              fwd;

      assign ra  = bus.rd_addr[i*ADDR_W +: ADDR_W];
      assign fwd = (BYPASS != 0) && wr_hit && (bus.wr_addr == ra);

      assign bus.rd_data[i*DATA_W +: DATA_W] = (ra == '0) ? '0          :
                                                fwd         ? bus.wr_data :
                                                              regs[ra];
      assign bus.rd_busy[i] = (ra != '0) && !fwd && pending[ra];
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a forwarding and a non-forwarding instance share one
// stimulus stream and are compared against an array-based reference model.
module tb_reg_file_mp;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 4;
   localparam int unsigned NR    = 2;
   localparam int unsigned DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;
   logic [NR*AW-1:0]  rd_addr;
   logic              issue_en;
   logic [AW-1:0]     issue_addr;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Reference state: register contents and pending flags
   logic [DW-1:0] mem  [DEPTH];
   bit            pend [DEPTH];

   reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_b ();
   reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_n ();

   assign bus_b.wr_en      = wr_en;
   assign bus_b.wr_addr    = wr_addr;
   assign bus_b.wr_data    = wr_data;
   assign bus_b.rd_addr    = rd_addr;
   assign bus_b.issue_en   = issue_en;
   assign bus_b.issue_addr = issue_addr;
   assign bus_n.wr_en      = wr_en;
   assign bus_n.wr_addr    = wr_addr;
   assign bus_n.wr_data    = wr_data;
   assign bus_n.rd_addr    = rd_addr;
   assign bus_n.issue_en   = issue_en;
   assign bus_n.issue_addr = issue_addr;

   reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) u_dut_byp (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) u_dut_nobyp (
      .clk (clk),
      .rst (rst),
      .bus (bus_n.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_data(input logic [AW-1:0] a, input bit byp);
      if (a == 0) return 32'h0;
      if (byp && wr_en && (wr_addr == a)) return wr_data;
      return mem[a];
   endfunction

   function automatic logic [31:0] exp_busy(input logic [AW-1:0] a, input bit byp);
      if (a == 0) return 32'h0;
      if (byp && wr_en && (wr_addr == a)) return 32'h0;
      return 32'(pend[a]);
   endfunction

   function automatic logic [31:0] exp_any();
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (pend[i]) return 32'h1;
      end
      return 32'h0;
   endfunction

   task automatic check_outputs();
      logic [AW-1:0] a;
      for (int p = 0; p < int'(NR); p++) begin
         a = rd_addr[p*AW +: AW];
         chk($sformatf("byp_data%0d", p),   bus_b.rd_data[p*DW +: DW], exp_data(a, 1'b1));
         chk($sformatf("nobyp_data%0d", p), bus_n.rd_data[p*DW +: DW], exp_data(a, 1'b0));
         chk($sformatf("byp_busy%0d", p),   32'(bus_b.rd_busy[p]),     exp_busy(a, 1'b1));
         chk($sformatf("nobyp_busy%0d", p), 32'(bus_n.rd_busy[p]),     exp_busy(a, 1'b0));
      end
      chk("byp_any_busy",   32'(bus_b.any_busy), exp_any());
      chk("nobyp_any_busy", 32'(bus_n.any_busy), exp_any());
   endtask

   task automatic model_update();
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i]  = '0;
            pend[i] = 1'b0;
         end
      end else begin
         if (wr_en && wr_addr != 0) begin
            mem[wr_addr]  = wr_data;
            pend[wr_addr] = 1'b0;
         end
         if (issue_en && issue_addr != 0) begin
            pend[issue_addr] = 1'b1;
         end
      end
   endtask

   // Check at the falling edge, advance one rising edge, return with inputs free to change
   task automatic cycle();
      @(negedge clk);
      if (!rst) check_outputs();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      wr_en    = 1'b0;
      issue_en = 1'b0;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
   endtask

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         mem[i]  = '0;
         pend[i] = 1'b0;
      end
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      issue_en = 1'b0; issue_addr = '0; rd_addr = '0;
      cycle();
      cycle();
      rst = 1'b0;

      // Post-reset sweep over every address on both ports
      for (int a = 0; a < int'(DEPTH); a++) begin
         set_rd(AW'(a), AW'(DEPTH - 1 - a));
         cycle();
      end
      #1 chk("reset_any_busy", 32'(bus_b.any_busy), 32'h0);

      // Write R5, read it on both ports; write to R0 is dropped
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
      cycle();
      idle(); set_rd(4'd5, 4'd5);
      #1 chk("r5_port0", bus_b.rd_data[31:0],  32'hDEADBEEF);
      chk("r5_port1", bus_b.rd_data[63:32], 32'hDEADBEEF);
      cycle();
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h1234;
      cycle();
      idle(); set_rd(4'd0, 4'd0);
      #1 chk("r0_stays_zero", bus_b.rd_data[31:0], 32'h0);
      cycle();

      // Same-cycle write and read of R7
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hA5A5A5A5; set_rd(4'd7, 4'd7);
      #1 chk("bypass_fwd",    bus_b.rd_data[31:0], 32'hA5A5A5A5);
      chk("nobypass_old",     bus_n.rd_data[31:0], 32'h0);
      cycle();

      // Issue R3, then retire it with a write
      idle(); issue_en = 1'b1; issue_addr = 4'd3;
      cycle();
      idle(); set_rd(4'd3, 4'd3);
      #1 chk("r3_busy",       32'(bus_b.rd_busy[0]), 32'h1);
      chk("r3_any_busy",      32'(bus_b.any_busy),   32'h1);
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h42;
      #1 chk("r3_byp_busy_wr",  32'(bus_b.rd_busy[0]), 32'h0);
      chk("r3_nobyp_busy_wr",   32'(bus_n.rd_busy[0]), 32'h1);
      cycle();
      idle();
      #1 chk("r3_busy_after", 32'(bus_n.rd_busy[1]),   32'h0);
      chk("r3_data",          bus_n.rd_data[63:32],    32'h42);
      cycle();

      // Simultaneous issue and write to R9; issue to R0 is dropped
      wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h77;
      issue_en = 1'b1; issue_addr = 4'd9;
      cycle();
      idle(); set_rd(4'd9, 4'd0);
      #1 chk("r9_data",       bus_n.rd_data[31:0],   32'h77);
      chk("r9_still_busy",    32'(bus_n.rd_busy[0]), 32'h1);
      cycle();
      issue_en = 1'b1; issue_addr = 4'd0;
      cycle();
      idle(); set_rd(4'd0, 4'd0);
      #1 chk("r0_never_busy", 32'(bus_b.rd_busy[1]), 32'h0);
      cycle();

      // Reset mid-operation discards data and pending state; strobes during reset are ignored
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h55;
      cycle();
      idle(); issue_en = 1'b1; issue_addr = 4'd4;
      cycle();
      rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'h99;
      issue_en = 1'b1; issue_addr = 4'd8;
      cycle();
      rst = 1'b0; idle(); set_rd(4'd2, 4'd6);
      #1 chk("r2_after_rst",  bus_b.rd_data[31:0],  32'h0);
      chk("r6_after_rst",     bus_b.rd_data[63:32], 32'h0);
      chk("any_busy_after_rst", 32'(bus_b.any_busy), 32'h0);
      cycle();

      // Random traffic with bias towards reading the address being written
      for (int n = 0; n < 3000; n++) begin
         rst        = ($urandom_range(63) == 0);
         wr_en      = 1'($urandom_range(1));
         wr_addr    = 4'($urandom_range(15));
         wr_data    = $urandom;
         issue_en   = ($urandom_range(2) == 0);
         issue_addr = ($urandom_range(3) == 0) ? wr_addr : 4'($urandom_range(15));
         rd_addr    = 8'($urandom_range(255));
         if ($urandom_range(3) == 0) rd_addr[3:0] = wr_addr;
         if ($urandom_range(3) == 0) rd_addr[7:4] = issue_addr;
         cycle();
      end
      rst = 1'b0; idle();
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
